// File: rtl/key_debounce_pkg.sv
// Shared types and 12 MHz default timing for the key debouncer.
// Auto-repeat is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
package key_pkg;

    typedef enum logic [1:0] {
        UP       = 2'd0,
        CHK_DOWN = 2'd1,
        DOWN     = 2'd2,
        CHK_UP   = 2'd3
    } key_st_e;

    localparam int unsigned CLK_HZ              = 12_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 120_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 6_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 1_200_000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: two-flop synchronizer, debounce FSM, pulse flops.
// Repeat counter only exists when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d, s2_q, s2_d;
    logic          sync_n;
    key_st_e       st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_tr, release_tr;
    logic          ev_press_q, ev_press_d;
    logic          ev_release_q, ev_release_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    assign sync_n = s2_q;

    always_comb begin
        s1_d       = key_n;
        s2_d       = s1_q;
        st_d       = st_q;
        cnt_d      = cnt_q;
        press_tr   = 1'b0;
        release_tr = 1'b0;
        unique case (st_q)
            UP: begin
                if (!sync_n) begin
                    st_d  = CHK_DOWN;
                    cnt_d = '0;
                end
            end
            CHK_DOWN: begin
                if (sync_n) begin
                    st_d = UP;
                end else if (cnt_q == CNT_LAST) begin
                    st_d     = DOWN;
                    press_tr = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOWN: begin
                if (sync_n) begin
                    st_d  = CHK_UP;
                    cnt_d = '0;
                end
            end
            CHK_UP: begin
                if (!sync_n) begin
                    st_d = DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    st_d       = UP;
                    release_tr = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: st_d = UP;
        endcase
        ev_release_d = release_tr;
        state_d      = (st_q == DOWN) || (st_q == CHK_UP);
        press_d      = ev_press_q;
        release_d    = ev_release_q;
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int unsigned RMAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW = cnt_width(RMAX);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rep_q, rep_d;
    logic          rep_fire;

    // Only a settled DOWN advances; CHK_UP and any exit restart the delay.
    always_comb begin
        rcnt_d   = '0;
        rep_d    = 1'b0;
        rep_fire = 1'b0;
        if (st_q == DOWN && !sync_n) begin
            rep_d = rep_q;
            if (rcnt_q == (rep_q ? PERIOD_LAST : DELAY_LAST)) begin
                rep_fire = 1'b1;
                rep_d    = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
        end
    end

    assign ev_press_d = press_tr | rep_fire;
`else
    assign ev_press_d = press_tr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            st_q         <= UP;
            cnt_q        <= '0;
            ev_press_q   <= 1'b0;
            ev_release_q <= 1'b0;
            state_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            ev_press_q   <= ev_press_d;
            ev_release_q <= ev_release_d;
            state_q      <= state_d;
            press_q      <= press_d;
            release_q    <= release_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer top: one key_debounce_ch per button.
// Define KEY_DEBOUNCE_REPEAT_EN for held-key auto-repeat pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'd16777215 ||
        REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("key_debounce: illegal timing parameters");
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .key_n      (key_n[g]),
            .key_state  (key_state[g]),
            .key_press  (key_press[g]),
            .key_release(key_release[g])
        );
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of independent push-button inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120000: stable-level cycles required (10 ms at 12 MHz); legal range 2..2^24-1.
REQ-003 SHALL have parameter REPEAT_DELAY, default 6000000: held cycles before first auto-repeat (0.5 s); used only with the repeat macro.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 1200000: cycles between auto-repeats (0.1 s); used only with the repeat macro.
REQ-005 SHALL have port clk, input, 1: the single clock; all flops on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous assert, active-high.
REQ-007 SHALL have port key_n, input, NUM_KEYS: raw asynchronous button pins, active-low (pulled up, low = pressed).
REQ-008 SHALL have port key_state, output, NUM_KEYS: debounced level, 1 = pressed.
REQ-009 SHALL have port key_press, output, NUM_KEYS: one-cycle pulse per accepted press (and per repeat).
REQ-010 SHALL have port key_release, output, NUM_KEYS: one-cycle pulse per accepted release.

Function
REQ-011 SHALL pass each key_n bit through a two-flop synchronizer before any other logic; the result is sync_n.
REQ-012 SHALL run one independent FSM per key with states UP, CHK_DOWN, DOWN, CHK_UP and its own counter of ceil(log2(max count)) bits.
REQ-013 UP: sync_n=0 -> CHK_DOWN with counter cleared; otherwise stay.
REQ-014 CHK_DOWN: sync_n=1 -> UP (glitch rejected, no pulse); else counter increments; at counter = DEBOUNCE_CYCLES-1 -> DOWN.
REQ-015 DOWN: sync_n=1 -> CHK_UP with counter cleared; otherwise stay.
REQ-016 CHK_UP: sync_n=0 -> DOWN (no pulse); else counter increments; at counter = DEBOUNCE_CYCLES-1 -> UP.
REQ-017 key_state SHALL be 1 exactly while the FSM is in DOWN or CHK_UP.
REQ-018 key_press SHALL be registered and high for exactly the one cycle after the CHK_DOWN->DOWN transition; key_release likewise for CHK_UP->UP.
REQ-019 Latency: with key_n steady low from clock edge E (first sampling edge), key_state and key_press SHALL rise after edge E+DEBOUNCE_CYCLES+3; release is symmetric.
REQ-020 A level held for only DEBOUNCE_CYCLES-1 synchronized cycles SHALL produce no pulse and no key_state change.
REQ-021 key_press and key_release of one key SHALL never be high in the same cycle; different keys SHALL be fully independent, and simultaneous events on several keys SHALL all be reported in the same cycle.
REQ-022 Counters SHALL saturate and never wrap.

Reset
REQ-023 While rst=1: synchronizer flops = 1 (released), all FSMs = UP, counters = 0, key_state = 0, key_press = 0, key_release = 0.
REQ-024 Reset asserted mid-debounce or while held SHALL discard progress without emitting any pulse; after release a held key is re-qualified from UP with full DEBOUNCE_CYCLES latency.

Configuration
REQ-025 Macro KEY_DEBOUNCE_REPEAT_EN: when defined, a key in DOWN for REPEAT_DELAY cycles SHALL pulse key_press again, then every REPEAT_PERIOD cycles while it stays in DOWN; the repeat counter clears on leaving DOWN and is not advanced in CHK_UP.
REQ-026 Without KEY_DEBOUNCE_REPEAT_EN: no repeat counter or logic is synthesized; exactly one key_press per accepted press.

Structure
REQ-027 A shared package key_pkg SHALL hold the FSM state enum (UP, CHK_DOWN, DOWN, CHK_UP) and the default timing constants for 12 MHz.
REQ-028 The per-key synchronizer, FSM, counters and pulse flops SHALL be one sub-module key_debounce_ch, instantiated NUM_KEYS times by a generate loop.

Verification (bench uses DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-029 Clean press: key_n[0] low from edge 10 -> key_state[0] and a single key_press[0] pulse after edge 21; other outputs stay 0.
REQ-030 Bounce: key_n[1] toggles low/high every 3 cycles for 30 cycles, then held low -> no output until 8 stable cycles, then exactly one key_press[1].
REQ-031 Release glitch: key held, key_n high for 5 cycles then low again -> key_state stays 1, no key_release.
REQ-032 Simultaneous: all four keys pressed on the same edge -> key_press = 4'b1111 for one cycle; release on the same edge -> key_release = 4'b1111 for one cycle.
REQ-033 Reset mid-operation: rst pulsed at counter = 5 in CHK_DOWN -> all outputs 0, no pulse; with the key still held after reset, key_press occurs 11 edges after rst deasserts.
REQ-034 Repeat (macro defined): key held 50 cycles after acceptance -> key_press pulses at +0, +20, +25, +30, +35, +40, +45; without the macro, only the +0 pulse.
